player_mover: RTL and testbench

- Sequential movement controller directly upstream of the 32x32 player-box wall checker.
- Once per frame tick, converts button inputs into a candidate position. The X and Y axes are resolved separately.
- Each candidate is driven onto the probe port of the wall checker; the move is committed only if no corner hits a wall.
- Output position feeds the sprite renderer and the wall checker.

---
 rtl/player_mover_pkg.sv | 17 +
 rtl/player_mover_axis_step.sv | 35 +++
 rtl/player_mover.sv | 193 +++++++++++++++++++
 tb/tb_player_mover.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_mover_pkg.sv
// rtl/player_mover_pkg.sv - shared game constants and movement FSM encoding
package player_mover_pkg;

   localparam int COORD_W       = 10;
   localparam int LEVEL_W       = 2;
   localparam int GAME_SCREEN_W = 640;
   localparam int GAME_SCREEN_H = 480;
   localparam int GAME_P_SIZE   = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT_X = 2'd1,
      ST_WAIT_Y = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/player_mover_axis_step.sv
// rtl/player_mover_axis_step.sv - one-axis candidate position with clamping to [0, limit]
module player_mover_axis_step
   import player_mover_pkg::*;
#(
   parameter int STEP = 2
) (
   input  logic [COORD_W-1:0] pos,
   input  logic               inc,
   input  logic               dec,
   input  logic [COORD_W-1:0] limit,
   output logic [COORD_W-1:0] cand
);

   localparam logic signed [COORD_W:0] STEP_S = (COORD_W+1)'(STEP);

   logic signed [COORD_W:0] delta;
   logic signed [COORD_W:0] sum;

   // One extra bit is enough: |STEP| <= 15 keeps the sum well inside the signed range.
   always_comb begin
      delta = '0;
      if (inc && !dec)
         delta = STEP_S;
      else if (dec && !inc)
         delta = -STEP_S;
      sum = $signed({1'b0, pos}) + delta;
      if (sum[COORD_W])
         cand = '0;
      else if (sum > $signed({1'b0, limit}))
         cand = limit;
      else
         cand = sum[COORD_W-1:0];
   end

endmodule

// File: rtl/player_mover.sv
// rtl/player_mover.sv - per-frame player movement with per-axis wall probing
module player_mover
   import player_mover_pkg::*;
#(
   parameter int STEP     = 2,
   parameter int START_X  = 64,
   parameter int START_Y  = 64,
   parameter int SCREEN_W = GAME_SCREEN_W,
   parameter int SCREEN_H = GAME_SCREEN_H,
   parameter int P_SIZE   = GAME_P_SIZE,
   parameter int WALL_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               level_load,
   input  logic [LEVEL_W-1:0] level_id,
   input  logic               is_wall,
   output logic [COORD_W-1:0] probe_x,
   output logic [COORD_W-1:0] probe_y,
   output logic [COORD_W-1:0] player_x,
   output logic [COORD_W-1:0] player_y,
   output logic               busy,
   output logic               move_done,
   output logic [1:0]         blocked
);

   localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(SCREEN_W - P_SIZE);
   localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(SCREEN_H - P_SIZE);
   localparam logic [COORD_W-1:0] X_START  = COORD_W'(START_X);
   localparam logic [COORD_W-1:0] Y_START  = COORD_W'(START_Y);
   localparam logic [1:0]         LAT_LAST = 2'(WALL_LAT - 1);

   state_t             state, state_nxt;
   logic [1:0]         lat_cnt;
   logic               lat_last;
   logic               hold_u, hold_d, hold_l, hold_r;
   logic               step_u, step_d, step_l, step_r;
   logic               dx_live, dy_live, dy_held;
   logic               x_blk;
   logic [COORD_W-1:0] cand_x, cand_y;
   logic               unused_level;

   // level_id is consumed by the neighbouring wall checker only.
   assign unused_level = ^level_id;

   assign lat_last = (lat_cnt == LAT_LAST);
   assign dx_live  = btn_right ^ btn_left;
   assign dy_live  = btn_down ^ btn_up;
   assign dy_held  = hold_down_xor();

   function automatic logic hold_down_xor();
      return hold_d ^ hold_u;
   endfunction

   // Live buttons feed the candidates only on the latch cycle; afterwards the held copy.
   always_comb begin
      step_u = hold_u;
      step_d = hold_d;
      step_l = hold_l;
      step_r = hold_r;
      if (state == ST_IDLE) begin
         step_u = btn_up;
         step_d = btn_down;
         step_l = btn_left;
         step_r = btn_right;
      end
   end

   player_mover_axis_step #(.STEP(STEP)) u_step_x (
      .pos   (player_x),
      .inc   (step_r),
      .dec   (step_l),
      .limit (X_MAX),
      .cand  (cand_x)
   );

   player_mover_axis_step #(.STEP(STEP)) u_step_y (
      .pos   (player_y),
      .inc   (step_d),
      .dec   (step_u),
      .limit (Y_MAX),
      .cand  (cand_y)
   );

   always_ff @(posedge clk) begin
      if (reset || level_load)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (frame_tick) begin
               if (dx_live)
                  state_nxt = ST_WAIT_X;
               else if (dy_live)
                  state_nxt = ST_WAIT_Y;
               else
                  state_nxt = ST_DONE;
            end
         end
         ST_WAIT_X: begin
            if (lat_last)
               state_nxt = dy_held ? ST_WAIT_Y : ST_DONE;
         end
         ST_WAIT_Y: begin
            if (lat_last)
               state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset || level_load) begin
         player_x  <= X_START;
         player_y  <= Y_START;
         probe_x   <= X_START;
         probe_y   <= Y_START;
         move_done <= 1'b0;
         blocked   <= 2'b00;
         lat_cnt   <= 2'd0;
         x_blk     <= 1'b0;
         {hold_u, hold_d, hold_l, hold_r} <= 4'b0000;
      end else begin
         move_done <= 1'b0;
         blocked   <= 2'b00;
         case (state)
            ST_IDLE: begin
               lat_cnt <= 2'd0;
               x_blk   <= 1'b0;
               probe_x <= player_x;
               probe_y <= player_y;
               if (frame_tick) begin
                  {hold_u, hold_d, hold_l, hold_r} <= {btn_up, btn_down, btn_left, btn_right};
                  if (dx_live)
                     probe_x <= cand_x;
                  else if (dy_live)
                     probe_y <= cand_y;
                  else
                     move_done <= 1'b1;
               end
            end
            ST_WAIT_X: begin
               if (lat_last) begin
                  lat_cnt <= 2'd0;
                  if (is_wall) begin
                     x_blk   <= 1'b1;
                     probe_x <= player_x;
                  end else begin
                     player_x <= probe_x;
                  end
                  if (dy_held) begin
                     probe_y <= cand_y;
                  end else begin
                     move_done <= 1'b1;
                     blocked   <= {1'b0, is_wall};
                  end
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            ST_WAIT_Y: begin
               if (lat_last) begin
                  lat_cnt <= 2'd0;
                  if (is_wall)
                     probe_y <= player_y;
                  else
                     player_y <= probe_y;
                  move_done <= 1'b1;
                  blocked   <= {is_wall, x_blk};
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_player_mover.sv
// tb/tb_player_mover.sv - directed vector bench for player_mover
module tb_player_mover;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] level_id;

   logic       a_tick, a_u, a_d, a_l, a_r, a_load, a_wall_en, a_is_wall;
   logic [9:0] a_wall_px, a_px, a_py, a_plx, a_ply;
   logic       a_busy, a_done;
   logic [1:0] a_blk;

   logic       b_tick, b_u, b_d, b_l, b_r, b_load, b_is_wall;
   logic [9:0] b_px, b_py, b_plx, b_ply;
   logic       b_busy, b_done;
   logic [1:0] b_blk;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign a_is_wall = a_wall_en && (a_px == a_wall_px);

   player_mover dut_a (
      .clk(clk), .reset(reset), .frame_tick(a_tick),
      .btn_up(a_u), .btn_down(a_d), .btn_left(a_l), .btn_right(a_r),
      .level_load(a_load), .level_id(level_id), .is_wall(a_is_wall),
      .probe_x(a_px), .probe_y(a_py), .player_x(a_plx), .player_y(a_ply),
      .busy(a_busy), .move_done(a_done), .blocked(a_blk)
   );

   player_mover #(.START_X(1), .START_Y(447), .WALL_LAT(3)) dut_b (
      .clk(clk), .reset(reset), .frame_tick(b_tick),
      .btn_up(b_u), .btn_down(b_d), .btn_left(b_l), .btn_right(b_r),
      .level_load(b_load), .level_id(level_id), .is_wall(b_is_wall),
      .probe_x(b_px), .probe_y(b_py), .player_x(b_plx), .player_y(b_ply),
      .busy(b_busy), .move_done(b_done), .blocked(b_blk)
   );

   typedef struct {
      logic       load;
      logic [3:0] btn;      // {up, down, left, right}
      logic       wall_en;
      logic [9:0] wall_px;
      logic [9:0] ex;
      logic [9:0] ey;
      logic [1:0] eblk;
      int         elat;
      logic [9:0] eypx;     // x seen while y is probed; 1023 means no y probe
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick_a(input logic [3:0] btn, output int lat, output logic [9:0] ypx,
                         output logic moved);
      @(negedge clk);
      {a_u, a_d, a_l, a_r} = btn;
      a_tick = 1'b1;
      @(negedge clk);
      a_tick = 1'b0;
      {a_u, a_d, a_l, a_r} = 4'b0000;
      lat = 1;
      ypx = 10'd1023;
      moved = 1'b0;
      while (!a_done && lat < 40) begin
         if (a_py != a_ply) ypx = a_px;
         if (a_px != a_plx || a_py != a_ply) moved = 1'b1;
         @(negedge clk);
         lat++;
      end
      chk("a_done_seen", int'(a_done), 1);
   endtask

   task automatic tick_b(input logic [3:0] btn, output int lat);
      @(negedge clk);
      {b_u, b_d, b_l, b_r} = btn;
      b_tick = 1'b1;
      @(negedge clk);
      b_tick = 1'b0;
      {b_u, b_d, b_l, b_r} = 4'b0000;
      lat = 1;
      while (!b_done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("b_done_seen", int'(b_done), 1);
   endtask

   // Right move on dut_b with is_wall driven per hold cycle from pat[0..2].
   task automatic b_probe(input string nm, input logic [2:0] pat, input int ex, input int eblk);
      @(negedge clk);
      b_r    = 1'b1;
      b_tick = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         b_tick    = 1'b0;
         b_r       = 1'b0;
         b_is_wall = pat[c];
      end
      @(negedge clk);
      b_is_wall = 1'b0;
      chk({nm, "_done"}, int'(b_done), 1);
      chk({nm, "_blk"}, int'(b_blk), eblk);
      chk({nm, "_x"}, int'(b_plx), ex);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int         lat, pulses;
      logic [9:0] ypx;
      logic       moved;

      vt[0]  = '{1'b0, 4'b0000, 1'b0, 10'd0,  10'd64, 10'd64, 2'b00, 1, 10'd1023};
      vt[1]  = '{1'b0, 4'b0001, 1'b0, 10'd0,  10'd66, 10'd64, 2'b00, 2, 10'd1023};
      vt[2]  = '{1'b0, 4'b0001, 1'b0, 10'd0,  10'd68, 10'd64, 2'b00, 2, 10'd1023};
      vt[3]  = '{1'b0, 4'b0001, 1'b0, 10'd0,  10'd70, 10'd64, 2'b00, 2, 10'd1023};
      vt[4]  = '{1'b1, 4'b0101, 1'b1, 10'd66, 10'd64, 10'd66, 2'b01, 3, 10'd64};
      vt[5]  = '{1'b0, 4'b0011, 1'b0, 10'd0,  10'd64, 10'd66, 2'b00, 1, 10'd1023};
      vt[6]  = '{1'b0, 4'b1000, 1'b0, 10'd0,  10'd64, 10'd64, 2'b00, 2, 10'd64};
      vt[7]  = '{1'b0, 4'b0010, 1'b1, 10'd62, 10'd64, 10'd64, 2'b01, 2, 10'd1023};
      vt[8]  = '{1'b0, 4'b1010, 1'b0, 10'd0,  10'd62, 10'd62, 2'b00, 3, 10'd62};
      vt[9]  = '{1'b0, 4'b0100, 1'b1, 10'd62, 10'd62, 10'd62, 2'b10, 2, 10'd62};
      vt[10] = '{1'b0, 4'b1100, 1'b0, 10'd0,  10'd62, 10'd62, 2'b00, 1, 10'd1023};
      vt[11] = '{1'b0, 4'b0110, 1'b1, 10'd60, 10'd62, 10'd64, 2'b01, 3, 10'd62};

      reset = 1'b1;
      level_id = 2'd1;
      {a_tick, a_u, a_d, a_l, a_r, a_load, a_wall_en} = '0;
      a_wall_px = '0;
      {b_tick, b_u, b_d, b_l, b_r, b_load, b_is_wall} = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst_a_x", int'(a_plx), 64);
      chk("rst_a_y", int'(a_ply), 64);
      chk("rst_a_px", int'(a_px), 64);
      chk("rst_a_py", int'(a_py), 64);
      chk("rst_a_busy", int'(a_busy), 0);
      chk("rst_a_done", int'(a_done), 0);
      chk("rst_a_blk", int'(a_blk), 0);
      chk("rst_b_x", int'(b_plx), 1);
      chk("rst_b_y", int'(b_ply), 447);

      for (int i = 0; i < 12; i++) begin
         if (vt[i].load) begin
            @(negedge clk);
            a_load = 1'b1;
            @(negedge clk);
            a_load = 1'b0;
         end
         a_wall_en = vt[i].wall_en;
         a_wall_px = vt[i].wall_px;
         tick_a(vt[i].btn, lat, ypx, moved);
         chk($sformatf("v%0d_lat", i), lat, vt[i].elat);
         chk($sformatf("v%0d_x", i), int'(a_plx), int'(vt[i].ex));
         chk($sformatf("v%0d_y", i), int'(a_ply), int'(vt[i].ey));
         chk($sformatf("v%0d_blk", i), int'(a_blk), int'(vt[i].eblk));
         chk($sformatf("v%0d_ypx", i), int'(ypx), int'(vt[i].eypx));
         chk($sformatf("v%0d_probed", i), int'(moved), (vt[i].elat != 1) ? 1 : 0);
         @(negedge clk);
         chk($sformatf("v%0d_pulse", i), int'(a_done), 0);
      end
      a_wall_en = 1'b0;

      // Cycle-exact diagonal latency from (64,64).
      @(negedge clk);
      a_load = 1'b1;
      @(negedge clk);
      a_load = 1'b0;
      {a_d, a_r} = 2'b11;
      a_tick = 1'b1;
      @(negedge clk);
      a_tick = 1'b0;
      {a_d, a_r} = 2'b00;
      chk("lat1_px", int'(a_px), 66);
      chk("lat1_x", int'(a_plx), 64);
      chk("lat1_busy", int'(a_busy), 1);
      @(negedge clk);
      chk("lat2_x", int'(a_plx), 66);
      chk("lat2_py", int'(a_py), 66);
      chk("lat2_y", int'(a_ply), 64);
      @(negedge clk);
      chk("lat3_y", int'(a_ply), 66);
      chk("lat3_done", int'(a_done), 1);
      @(negedge clk);
      chk("lat4_done", int'(a_done), 0);
      chk("lat4_busy", int'(a_busy), 0);

      // level_load while the X probe is in flight.
      a_r = 1'b1;
      a_tick = 1'b1;
      @(negedge clk);
      a_tick = 1'b0;
      a_r = 1'b0;
      a_load = 1'b1;
      @(negedge clk);
      a_load = 1'b0;
      chk("ld_x", int'(a_plx), 64);
      chk("ld_y", int'(a_ply), 64);
      chk("ld_px", int'(a_px), 64);
      chk("ld_busy", int'(a_busy), 0);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (a_done) pulses++;
         @(negedge clk);
      end
      chk("ld_pulses", pulses, 0);

      // Second tick while busy is dropped.
      a_r = 1'b1;
      a_tick = 1'b1;
      @(negedge clk);
      a_r = 1'b0;
      a_l = 1'b1;
      @(negedge clk);
      a_tick = 1'b0;
      a_l = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         if (a_done) pulses++;
         @(negedge clk);
      end
      chk("busy_pulses", pulses, 1);
      chk("busy_x", int'(a_plx), 66);

      tick_a(4'b0011, lat, ypx, moved);
      chk("opp_lat", lat, 1);
      chk("opp_probed", int'(moved), 0);
      chk("opp_blk", int'(a_blk), 0);

      // WALL_LAT = 3 instance: edge clamping and sample timing.
      tick_b(4'b0110, lat);
      chk("clamp1_lat", lat, 7);
      chk("clamp1_x", int'(b_plx), 0);
      chk("clamp1_y", int'(b_ply), 448);
      chk("clamp1_blk", int'(b_blk), 0);
      tick_b(4'b0110, lat);
      chk("clamp2_lat", lat, 7);
      chk("clamp2_x", int'(b_plx), 0);
      chk("clamp2_y", int'(b_ply), 448);
      chk("clamp2_blk", int'(b_blk), 0);

      b_probe("wl3_hit", 3'b100, 0, 1);
      b_probe("wl3_early", 3'b011, 2, 0);

      tick_b(4'b0011, lat);
      chk("b_opp_lat", lat, 1);
      chk("b_opp_x", int'(b_plx), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
